// File: rtl/sdram_write.sv
// Write-path command sequencer: requests the SDRAM bus, then writes NUM_ROWS rows
// in BL4 bursts from a show-ahead FIFO, yielding at burst boundaries for refresh.
module sdram_write #(
    parameter int          NUM_ROWS  = 3,
    parameter logic [11:0] START_ROW = 12'd0,
    parameter int          DATA_W    = 16
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              wr_trig,
    output logic              wr_req,
    input  logic              wr_en,
    input  logic              ref_req,
    output logic              flag_wr_end,
    input  logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ack,
    output logic [3:0]        wr_cmd,
    output logic [11:0]       wr_addr,
    output logic [1:0]        bank_addr,
    output logic [DATA_W-1:0] wr_dq,
    output logic              wr_dq_oe,
    output logic [2:0]        dbg_state
);

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_ACT  = 4'b0011;
    localparam logic [3:0]  CMD_WR   = 4'b0100;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [11:0] LAST_ROW = START_ROW + 12'(NUM_ROWS - 1);
    localparam logic [8:0]  LAST_COL = 9'd508;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_ACT  = 3'd2,
        S_WR   = 3'd3,
        S_PRE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        R_DONE  = 2'd0,
        R_BREAK = 2'd1,
        R_ROW   = 2'd2
    } reason_t;

    state_t      state, state_nxt;
    reason_t     reason, reason_nxt;
    logic [1:0]  act_cnt, pre_cnt, beat;
    logic [11:0] row;
    logic [8:0]  col;
    logic [3:0]  cmd_nxt;
    logic [11:0] addr_nxt;
    logic        flag_nxt;
    logic        row_end, last_burst;

    assign row_end    = (col == LAST_COL);
    assign last_burst = row_end && (row == LAST_ROW);
    assign wr_req     = (state == S_REQ);
    assign bank_addr  = 2'b00;
    assign dbg_state  = state;

    // Handshakes: wr_req/wr_en is a level request held until the grant is seen in REQ;
    // src_ack marks the cycle the FIFO head word is taken, valid only when src_ready
    // (or mid-burst, where src_ready already guaranteed four words).
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state  <= S_IDLE;
            reason <= R_DONE;
        end else begin
            state  <= state_nxt;
            reason <= reason_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        reason_nxt = reason;
        case (state)
            S_IDLE: if (wr_trig) state_nxt = S_REQ;
            S_REQ:  if (wr_en) state_nxt = S_ACT;
            S_ACT:  if (act_cnt == 2'd3) state_nxt = S_WR;
            S_WR: begin
                if (beat == 2'd0 && !src_ready) begin
                    if (ref_req) begin
                        state_nxt  = S_PRE;
                        reason_nxt = R_BREAK;
                    end
                end else if (beat == 2'd3) begin
                    if (last_burst) begin
                        state_nxt  = S_PRE;
                        reason_nxt = R_DONE;
                    end else if (ref_req) begin
                        state_nxt  = S_PRE;
                        reason_nxt = R_BREAK;
                    end else if (row_end) begin
                        state_nxt  = S_PRE;
                        reason_nxt = R_ROW;
                    end
                end
            end
            S_PRE: begin
                if (pre_cnt == 2'd3) begin
                    case (reason)
                        R_DONE:  state_nxt = S_IDLE;
                        R_BREAK: state_nxt = S_REQ;
                        default: state_nxt = S_ACT;
                    endcase
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_nxt  = CMD_NOP;
        addr_nxt = 12'd0;
        flag_nxt = 1'b0;
        src_ack  = (state == S_WR) && (beat != 2'd0 || src_ready);
        if (state == S_ACT && act_cnt == 2'd0) begin
            cmd_nxt  = CMD_ACT;
            addr_nxt = row;
        end else if (state == S_WR && beat == 2'd0 && src_ready) begin
            cmd_nxt  = CMD_WR;
            addr_nxt = {3'b000, col};
        end else if (state == S_PRE && pre_cnt == 2'd0) begin
            cmd_nxt  = CMD_PRE;
            addr_nxt = 12'h400;
        end
        if (state == S_PRE && pre_cnt == 2'd3 && reason != R_ROW)
            flag_nxt = 1'b1;
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            act_cnt     <= 2'd0;
            pre_cnt     <= 2'd0;
            beat        <= 2'd0;
            row         <= 12'd0;
            col         <= 9'd0;
            wr_cmd      <= CMD_NOP;
            wr_addr     <= 12'd0;
            wr_dq       <= '0;
            wr_dq_oe    <= 1'b0;
            flag_wr_end <= 1'b0;
        end else begin
            act_cnt <= (state == S_ACT) ? act_cnt + 2'd1 : 2'd0;
            pre_cnt <= (state == S_PRE) ? pre_cnt + 2'd1 : 2'd0;
            if (state != S_WR)
                beat <= 2'd0;
            else if (src_ack)
                beat <= beat + 2'd1;

            if (state == S_IDLE && wr_trig) begin
                row <= START_ROW;
                col <= 9'd0;
            end else if (state == S_WR && beat == 2'd3 && !last_burst) begin
                // col wraps to 0 at a row end; a refresh break there resumes on the next row.
                col <= col + 9'd4;
                if (ref_req && row_end)
                    row <= row + 12'd1;
            end else if (state == S_PRE && pre_cnt == 2'd3 && reason == R_ROW) begin
                row <= row + 12'd1;
            end

            wr_cmd      <= cmd_nxt;
            wr_addr     <= addr_nxt;
            flag_wr_end <= flag_nxt;
            wr_dq_oe    <= src_ack;
            if (src_ack)
                wr_dq <= src_data;
        end
    end

endmodule

// File: tb/tb_sdram_write.sv
// Directed bench for sdram_write: reset, startup latency, full job, refresh break,
// source stall and the final-beat refresh collision.
module tb_sdram_write;

    localparam int          DATA_W    = 16;
    localparam int          NUM_ROWS  = 3;
    localparam logic [11:0] START_ROW = 12'd0;
    localparam logic [3:0]  CMD_NOP   = 4'b0111;
    localparam logic [3:0]  CMD_ACT   = 4'b0011;
    localparam logic [3:0]  CMD_WR    = 4'b0100;
    localparam logic [3:0]  CMD_PRE   = 4'b0010;

    logic              sclk, s_rst, wr_trig, wr_req, wr_en, ref_req, flag_wr_end;
    logic              src_ready, src_ack, wr_dq_oe;
    logic [DATA_W-1:0] src_data, wr_dq;
    logic [3:0]        wr_cmd;
    logic [11:0]       wr_addr;
    logic [1:0]        bank_addr;
    logic [2:0]        dbg_state;

    sdram_write #(.NUM_ROWS(NUM_ROWS), .START_ROW(START_ROW), .DATA_W(DATA_W)) dut (
        .sclk(sclk), .s_rst(s_rst), .wr_trig(wr_trig), .wr_req(wr_req), .wr_en(wr_en),
        .ref_req(ref_req), .flag_wr_end(flag_wr_end), .src_ready(src_ready),
        .src_data(src_data), .src_ack(src_ack), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .bank_addr(bank_addr), .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe), .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // clock / reset
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge sclk);
        cyc++;
    end

    // monitor, source FIFO model and data scoreboard
    logic [DATA_W-1:0] exp_q[$];
    logic [11:0]       act_log[$];
    event              mon_done;
    int idx = 0, job_base = 0;
    int n_act = 0, n_wr = 0, n_pre = 0, n_flag = 0, n_req = 0, n_ack = 0;
    int last_act_cyc = -1, last_wr_cyc = -1, last_pre_cyc = -1, last_flag_cyc = -1;
    int last_ack_cyc = -1, req_rise_cyc = -1, oe_rise_cyc = -1, act_gap = -1;
    logic [11:0] last_act_addr = 12'hfff, last_wr_addr = 12'hfff;
    logic ack_prev = 1'b0, req_prev = 1'b0, oe_prev = 1'b0;
    int got_off, exp_off;

    initial begin
        src_data = DATA_W'(16'h1000);
        forever begin
            @(negedge sclk);
            if (ack_prev) idx++;
            src_data = DATA_W'(16'h1000 + idx[15:0]);
            if (wr_dq_oe) begin
                if (exp_q.size() == 0) check_eq("dq_unexpected", 32'(wr_dq_oe), 32'd0);
                else check_eq("dq", 32'(wr_dq), 32'(exp_q.pop_front()));
            end else if (exp_q.size() != 0) begin
                check_eq("oe", 32'(wr_dq_oe), 32'd1);
                exp_q.delete();
            end
            case (wr_cmd)
                CMD_ACT: begin
                    n_act++;
                    if (n_pre > 0) act_gap = cyc - last_pre_cyc;
                    last_act_cyc  = cyc;
                    last_act_addr = wr_addr;
                    act_log.push_back(wr_addr);
                end
                CMD_WR: begin
                    n_wr++;
                    last_wr_cyc  = cyc;
                    last_wr_addr = wr_addr;
                    got_off = int'(16'(wr_dq - 16'h1000 - job_base[15:0]));
                    exp_off = int'(last_act_addr - START_ROW) * 512 + int'(wr_addr);
                    check_eq("wr_data_at_col", 32'(got_off), 32'(exp_off));
                end
                CMD_PRE: begin
                    n_pre++;
                    last_pre_cyc = cyc;
                    check_eq("pre_addr", 32'(wr_addr), 32'h400);
                end
                default: ;
            endcase
            if (flag_wr_end) begin
                n_flag++;
                last_flag_cyc = cyc;
            end
            if (wr_req) n_req++;
            if (wr_req && !req_prev) req_rise_cyc = cyc;
            if (wr_dq_oe && !oe_prev) oe_rise_cyc = cyc;
            if (src_ack) begin
                n_ack++;
                last_ack_cyc = cyc;
            end
            if (src_ack && !s_rst) exp_q.push_back(src_data);
            ack_prev = src_ack;
            req_prev = wr_req;
            oe_prev  = wr_dq_oe;
            -> mon_done;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic start_job();
        job_base = idx;
        wr_trig  = 1'b1;
        tick();
        wr_trig  = 1'b0;
    endtask

    task automatic wait_flag(input string tag, input int budget, output int f);
        int start = n_flag;
        int k = 0;
        while (n_flag == start && k < budget) begin
            @(mon_done);
            k++;
        end
        check_eq(tag, 32'(n_flag != start), 32'd1);
        f = cyc;
    endtask

    task automatic wait_write(input string tag, input logic [11:0] row, input logic [11:0] addr,
                              output int c);
        int k = 0;
        logic found = 1'b0;
        while (!found && k < 3000) begin
            @(mon_done);
            k++;
            if (last_wr_cyc == cyc && last_wr_addr == addr && last_act_addr == row) found = 1'b1;
        end
        check_eq(tag, 32'(found), 32'd1);
        c = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd"}, 32'(wr_cmd), 32'(CMD_NOP));
        check_eq({tag, "_addr"}, 32'(wr_addr), 32'd0);
        check_eq({tag, "_dq"}, 32'(wr_dq), 32'd0);
        check_eq({tag, "_oe"}, 32'(wr_dq_oe), 32'd0);
        check_eq({tag, "_flag"}, 32'(flag_wr_end), 32'd0);
        check_eq({tag, "_req"}, 32'(wr_req), 32'd0);
        check_eq({tag, "_ack"}, 32'(src_ack), 32'd0);
        check_eq({tag, "_bank"}, 32'(bank_addr), 32'd0);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    int t, c, f, g, a0, w0, r0, p0, fl0, q0;

    initial begin
        s_rst = 1'b1; wr_trig = 1'b0; wr_en = 1'b0; ref_req = 1'b0; src_ready = 1'b1;
        repeat (3) tick();
        s_rst = 1'b0;
        @(mon_done);
        check_reset_outputs("por");

        // reset in the middle of a job
        wr_en = 1'b1;
        start_job();
        wait_write("rst_job_to", 12'd0, 12'd16, c);
        tick();
        s_rst = 1'b1;
        tick();
        @(mon_done);
        check_reset_outputs("rst_mid");
        tick();
        tick();
        s_rst = 1'b0;
        @(mon_done);
        check_reset_outputs("rst_after");

        // startup latency
        wr_en = 1'b0;
        tick();
        t  = cyc;
        q0 = n_req;
        start_job();
        repeat (4) tick();
        wr_en = 1'b1;
        while (cyc < t + 12) @(mon_done);
        check_eq("req_rise", 32'(req_rise_cyc), 32'(t + 1));
        check_eq("act_cyc", 32'(last_act_cyc), 32'(t + 7));
        check_eq("act_row", 32'(last_act_addr), 32'd0);
        check_eq("first_wr_cyc", 32'(last_wr_cyc), 32'(t + 11));
        check_eq("first_wr_col", 32'(last_wr_addr), 32'd0);
        check_eq("oe_rise", 32'(oe_rise_cyc), 32'(t + 11));
        wait_flag("startup_end_to", 4000, f);
        check_eq("req_cycles", 32'(n_req - q0), 32'd5);

        // full job with grant tied high
        tick();
        a0 = n_ack; w0 = n_wr; r0 = n_act; p0 = n_pre; fl0 = n_flag; q0 = n_req;
        act_log.delete();
        start_job();
        wait_flag("full_end_to", 4000, f);
        repeat (3) @(mon_done);
        check_eq("full_acks", 32'(n_ack - a0), 32'd1536);
        check_eq("full_writes", 32'(n_wr - w0), 32'd384);
        check_eq("full_acts", 32'(n_act - r0), 32'd3);
        check_eq("full_pres", 32'(n_pre - p0), 32'd3);
        check_eq("full_flags", 32'(n_flag - fl0), 32'd1);
        check_eq("full_req", 32'(n_req - q0), 32'd1);
        for (int i = 0; i < 3; i++)
            check_eq("full_act_row", 32'(act_log.size() > i ? act_log[i] : 12'hfff), 32'(i));
        check_eq("beat_to_pre", 32'(last_pre_cyc - last_ack_cyc), 32'd2);
        check_eq("pre_to_flag", 32'(last_flag_cyc - last_pre_cyc), 32'd3);
        check_eq("pre_to_act", 32'(act_gap), 32'd4);
        check_eq("full_idle", 32'(dbg_state), 32'd0);

        // refresh break at row 1 col 100
        a0 = n_ack; w0 = n_wr; r0 = n_act; p0 = n_pre; fl0 = n_flag;
        start_job();
        wait_write("brk_find_to", 12'd1, 12'd100, c);
        tick();
        ref_req = 1'b1;
        wr_en   = 1'b0;
        tick();
        tick();
        ref_req = 1'b0;
        wait_flag("brk_flag_to", 200, f);
        check_eq("brk_flag_cyc", 32'(f), 32'(c + 7));
        check_eq("brk_pre_cyc", 32'(last_pre_cyc), 32'(c + 4));
        check_eq("brk_req", 32'(wr_req), 32'd1);
        check_eq("brk_wr_after", 32'(last_wr_cyc), 32'(c));
        repeat (3) @(mon_done);
        check_eq("brk_req_hold", 32'(wr_req), 32'd1);
        tick();
        g = cyc;
        wr_en = 1'b1;
        while (cyc < g + 6) @(mon_done);
        check_eq("brk_act_cyc", 32'(last_act_cyc), 32'(g + 2));
        check_eq("brk_act_row", 32'(last_act_addr), 32'd1);
        check_eq("brk_wr_cyc", 32'(last_wr_cyc), 32'(g + 6));
        check_eq("brk_wr_col", 32'(last_wr_addr), 32'd104);
        wait_flag("brk_end_to", 4000, f);
        repeat (2) @(mon_done);
        check_eq("brk_acks", 32'(n_ack - a0), 32'd1536);
        check_eq("brk_writes", 32'(n_wr - w0), 32'd384);
        check_eq("brk_acts", 32'(n_act - r0), 32'd4);
        check_eq("brk_pres", 32'(n_pre - p0), 32'd4);
        check_eq("brk_flags", 32'(n_flag - fl0), 32'd2);

        // source stall before col 200
        start_job();
        wait_write("stall_find_to", 12'd0, 12'd196, c);
        tick();
        src_ready = 1'b0;
        @(mon_done);
        @(mon_done);
        a0 = n_ack;
        w0 = n_wr;
        repeat (10) @(mon_done);
        check_eq("stall_acks", 32'(n_ack - a0), 32'd0);
        check_eq("stall_writes", 32'(n_wr - w0), 32'd0);
        check_eq("stall_cmd", 32'(wr_cmd), 32'(CMD_NOP));
        tick();
        src_ready = 1'b1;
        @(mon_done);
        @(mon_done);
        check_eq("stall_wr_cyc", 32'(last_wr_cyc), 32'(c + 14));
        check_eq("stall_wr_col", 32'(last_wr_addr), 32'd200);
        check_eq("stall_resume_acks", 32'(n_ack - a0), 32'd2);
        wait_flag("stall_end_to", 4000, f);

        // refresh collides with the final beat
        tick();
        fl0 = n_flag;
        start_job();
        wait_write("coll_find_to", 12'd2, 12'd508, c);
        tick();
        ref_req = 1'b1;
        q0 = n_req;
        wait_flag("coll_flag_to", 200, f);
        check_eq("coll_flag_cyc", 32'(f), 32'(c + 7));
        check_eq("coll_pre_cyc", 32'(last_pre_cyc), 32'(c + 4));
        repeat (20) @(mon_done);
        check_eq("coll_no_req", 32'(n_req - q0), 32'd0);
        check_eq("coll_flags", 32'(n_flag - fl0), 32'd1);
        check_eq("coll_idle", 32'(dbg_state), 32'd0);
        ref_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_write.md
# sdram_write

Write-path command sequencer for the single-bank SDRAM controller, the counterpart of the read sequencer. On a trigger it requests the command bus from the controller arbiter, then writes `NUM_ROWS` consecutive rows (512 columns each, burst length 4) starting at `START_ROW` of bank 0. Write data is pulled from a show-ahead source FIFO. The block yields the bus at burst boundaries for auto-refresh and resumes where it stopped.

## Interface
- `NUM_ROWS`, default 3: rows written per job.
- `START_ROW`, default 0: first row address (12 bit).
- `DATA_W`, default 16: SDRAM data width.

Ports:
- `sclk` in 1: clock.
- `s_rst` in 1: reset, synchronous, active-high.
- `wr_trig` in 1: job start pulse; sampled only in IDLE.
- `wr_req` out 1: bus request to arbiter; equals (state==REQ), combinational.
- `wr_en` in 1: arbiter grant; sampled only in REQ.
- `ref_req` in 1: refresh pending from refresh timer.
- `flag_wr_end` out 1: one-cycle pulse when the bus is released (job done or refresh break).
- `src_ready` in 1: source holds at least 4 words.
- `src_data` in DATA_W: show-ahead FIFO head word.
- `src_ack` out 1: word consumed this cycle, combinational.
- `wr_cmd` out 4: {CS,RAS,CAS,WE}. NOP 0111, ACT 0011, WRITE 0100, PRE 0010.
- `wr_addr` out 12: SDRAM address.
- `bank_addr` out 2: constant 0.
- `wr_dq` out DATA_W: write data.
- `wr_dq_oe` out 1: data bus drive enable.

## Operation
- States: IDLE, REQ, ACT, WR, PRE.
- IDLE: when `wr_trig` is high, go to REQ and load row=START_ROW, col=0.
- REQ: when `wr_en` is high, go to ACT.
- ACT: lasts 4 cycles (act_cnt 0..3).
  - act_cnt 0 issues ACT with `wr_addr`=row.
  - Then go to WR.
- WR, beat counter 0..3.
  - Beat 0 with `src_ready`=1: issue WRITE, `wr_addr`={3'b000, col[8:0]} (A10=0, no auto-precharge).
  - Beats 0..3: `src_ack`=1 and `src_data` is driven with `wr_dq_oe`=1.
  - Beats 1..3 issue NOP.
  - Beat 0 with `src_ready`=0: NOP, no ack, counter held at 0. If `ref_req` is also high, go to PRE with reason BREAK.
  - At beat 3, in priority order:
    - col==508 and row==START_ROW+NUM_ROWS-1: go to PRE, reason DONE.
    - `ref_req`: go to PRE, reason BREAK; col+=4.
    - col==508: go to PRE, reason ROW; col=0.
    - Otherwise: beat 0 of the next burst, col+=4.
- PRE: lasts 4 cycles (pre_cnt 0..3).
  - pre_cnt 0 issues PRE with `wr_addr`=12'h400 (A10=1, all banks).
  - At pre_cnt 3:
    - DONE: go to IDLE and pulse `flag_wr_end`.
    - BREAK: go to REQ and pulse `flag_wr_end`; row and col are kept.
    - ROW: row+=1, go to ACT; the bus is kept, no pulse.
- Column arithmetic: 9-bit, always a multiple of 4. Row: 12-bit, no wrap within a job.
- `wr_trig` outside IDLE and `wr_en` outside REQ are ignored.

## Timing
- `wr_cmd`, `wr_addr`, `wr_dq`, `wr_dq_oe` and `flag_wr_end` are registered. Each appears on the cycle after the state/counter value that produces it.
- `wr_dq` is captured from `src_data` on every `src_ack` cycle, so data is aligned with its WRITE/NOP command (zero write latency).
- Latencies:
  - `wr_trig` at T gives `wr_req`=1 at T+1.
  - `wr_en` at E gives ACT on `wr_cmd` at E+2 and the first WRITE at E+6 (tRCD=4).
  - Bursts with `src_ready` held high are back-to-back: WRITE every 4 cycles, `wr_dq_oe` continuous.
  - Last beat to PRE command: 2 cycles. PRE command to next ACT command: 4 cycles (tRP).
- Reset values: state IDLE, `wr_cmd`=0111, `wr_addr`=0, `wr_dq`=0, `wr_dq_oe`=0, `flag_wr_end`=0, `wr_req`=0, `src_ack`=0, row=col=0.
- Reset mid-job: IDLE on the next edge and outputs at reset values. No PRE is issued; the controller must re-init.
- Simultaneous DONE and `ref_req` at the final beat: DONE wins (single `flag_wr_end`); the arbiter services the refresh afterwards.
- `ref_req` mid-burst: the burst is completed first; it is never truncated.

## Test plan
- Reset: hold `s_rst` 3 cycles during a job -> next cycle all outputs at the reset values; `wr_req`=0.
- Full job, defaults, `src_ready`=1, `wr_en` tied high:
  - 1536 `src_ack` pulses and 384 WRITE commands (cols 0,4,…,508 per row).
  - ACT addresses 0, 1, 2; 3 PRE commands with `wr_addr`=0x400.
  - Exactly one `flag_wr_end` pulse; `wr_req` high for 1 cycle.
- Startup timing: `wr_trig` at T=10, `wr_en` asserted at 15 ->
  - `wr_req` high 11..15.
  - ACT at 17; WRITE addr 0 at 21.
  - `wr_dq_oe` high from 21 on, `wr_dq` equal to the source words.
- Refresh break: `ref_req` pulses during the burst at row 1 col 100 ->
  - Burst completes, PRE, `flag_wr_end` pulse, REQ.
  - After grant, ACT row 1, then WRITE col 104 (no data loss or duplication).
- Source stall: `src_ready`=0 for 10 cycles at col 200 -> NOP and `src_ack`=0 for 10 cycles, then WRITE col 200 with correct data.
- Final-beat collision: `ref_req` high at beat 3 of row 2 col 508 -> PRE, IDLE, single `flag_wr_end`, no REQ re-entry.
